vga_sprite_anim_core: RTL and testbench
=======================================

# vga_sprite_anim_core

Animated, palette-based sprite overlay for the video pixel stream. It is the parametrised successor of the single-image sprite cores and adds several features:
- multiple animation frames stored in one RAM;
- an indexed colour palette with a transparent index;
- optional horizontal mirroring;
- tear-free position and control updates that commit only at frame start.

It sits in a video slot between the frame counter and the next stage of the RGB chain, and is written by the CPU over the slot interface.

## Interface
- CD, 12, colour depth of si_rgb/so_rgb and palette entries
- SPRITE_W, 64, sprite width in pixels (power of 2)
- SPRITE_H, 32, sprite height in pixels (power of 2)
- FRAMES, 4, animation frame count (power of 2); FRAMES·SPRITE_W·SPRITE_H ≤ 8192
- PIX_BITS, 3, palette index width (1..3)
- KEY_INDEX, 0, palette index treated as transparent

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- x, y  in  11  current pixel coordinate from frame counter
- cs  in  1  slot chip select
- write  in  1  write strobe
- addr  in  14  CPU word address
- wr_data  in  32  CPU write data
- si_rgb  in  CD  upstream pixel
- so_rgb  out  CD  composited pixel, 2-cycle latency

## Operation
- RAM_AW = log2(FRAMES·SPRITE_W·SPRITE_H). Writes are qualified by `wr_en = cs & write`.
- addr[13]=0: sprite RAM write. Location is addr[RAM_AW-1:0]; data is wr_data[PIX_BITS-1:0]. Layout is {frame, row, col}.
- addr[13]=1: register write, decoded on addr[3:0]:
  - 0 ctrl: bit0 bypass, bit1 hflip, bit2 anim_en
  - 1 x0: wr_data[10:0]
  - 2 y0: wr_data[10:0]
  - 3 frame: manual frame index, wr_data[log2(FRAMES)-1:0]
  - 4 period: wr_data[7:0]; the animation advances every period+1 frames
  - 5..7: ignored
  - 8..15: palette entry addr[2:0] ← wr_data[CD-1:0]. Entries ≥ 2^PIX_BITS are ignored.
- Registers 0–3 are staging registers. Active copies load only on frame_tick.
- Palette and period take effect immediately.
- frame_tick: a one-cycle pulse on the first cycle where x==0 && y==0, and the previous cycle's coordinate was not (0,0).
- Animation state on frame_tick:
  - anim_en=0: active frame ← staged frame; divider ← 0.
  - anim_en=1: if divider==period, then divider ← 0 and active frame ← (active frame+1) mod FRAMES; otherwise divider ← divider+1.
- Hit test uses 11-bit unsigned differences dx = x−x0_act and dy = y−y0_act. A pixel is a hit iff dx<SPRITE_W && dy<SPRITE_H. Coordinates left of or above the origin wrap to large values and miss.
- col = dx[log2 W−1:0], or SPRITE_W−1−col when hflip_act=1. row = dy[log2 H−1:0].
- Output selection:
  - bypass_act=1 → so_rgb = delayed si_rgb.
  - Otherwise: a miss or an index equal to KEY_INDEX gives delayed si_rgb; any other index gives palette[index].
- RAM read-during-write to the same address returns the old data.

## Timing
- Pipeline:
  - Stage 1 registers hit, RAM address, si_rgb.
  - Stage 2 registers the synchronous RAM read, hit, si_rgb.
  - so_rgb is combinational from stage 2.
  - Total latency from x/y/si_rgb to so_rgb is exactly 2 clk.
- Reset values:
  - active and staging x0, y0, ctrl, frame: 0
  - period: 0
  - divider: 0
  - palette: all 0
  - pipeline registers: 0, so so_rgb=0 during reset and for 2 cycles after release
  - sprite RAM: not reset
- A register write in the same cycle as frame_tick updates staging only. The commit uses the pre-write value, so the new value becomes active at the next frame_tick.
- A period write during a frame does not reset the divider. If divider > new period, the divider continues to 255 and wraps to 0 before advancing; no frame advance occurs at that wrap.
- Reset asserted mid-frame clears all state on that edge. No frame_tick is generated by reset itself.
- x/y held at (0,0) for multiple cycles generates exactly one frame_tick.

## Configuration
- SPRITE_HFLIP_EN defined: ctrl bit1 is staged/committed and mirrors the column as above.
- SPRITE_HFLIP_EN undefined: the hflip logic and register bit are not built, ctrl bit1 is ignored, and col = dx always.

## Test plan
- Reset, then write x0=100, y0=50, fill frame 0 with index 1, palette[1]=12'hF00, si_rgb=12'h00F. After the next frame_tick: so_rgb=F00 two cycles after (x,y)=(100,50); so_rgb=00F at (99,50) and at (164,50).
- Write x0=200 mid-frame. The sprite stays at the old x0 until the next (0,0) pixel, then moves to 200. A write coinciding with frame_tick applies one frame later.
- Set anim_en=1, period=2, FRAMES=4, with each frame filled with a distinct index. The frame shown advances every 3 frame_ticks: 0,0,0,1,1,1,2,2,2,3,3,3,0.
- Write index KEY_INDEX=0 at one pixel → so_rgb=si_rgb there. Set ctrl bypass=1 → so_rgb=si_rgb everywhere from the next frame.
- With SPRITE_HFLIP_EN and hflip=1, a pixel written at col 0 appears at dx=63; undefined macro → it appears at dx=0.
- Assert reset mid-frame with the sprite visible. so_rgb=0 while reset is low and for 2 cycles after release, then equals si_rgb until registers are rewritten and committed.

Source files
------------

// File: rtl/vga_sprite_anim_core.sv
// Animated palette sprite overlay: multi-frame sprite RAM, indexed palette with a
// transparent key, tear-free commits at frame start. Define SPRITE_HFLIP_EN to build mirroring.
module vga_sprite_anim_core #(
  parameter int CD        = 12,
  parameter int SPRITE_W  = 64,
  parameter int SPRITE_H  = 32,
  parameter int FRAMES    = 4,
  parameter int PIX_BITS  = 3,
  parameter int KEY_INDEX = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int CW     = $clog2(SPRITE_W);
  localparam int RW     = $clog2(SPRITE_H);
  localparam int FW     = $clog2(FRAMES);
  localparam int RAM_AW = FW + RW + CW;
  localparam int NPAL   = 2 ** PIX_BITS;
  localparam logic [10:0]         W11 = 11'(SPRITE_W);
  localparam logic [10:0]         H11 = 11'(SPRITE_H);
  localparam logic [PIX_BITS-1:0] KEY = PIX_BITS'(KEY_INDEX);

  logic wr_en, reg_wr, ram_wr, pal_ok;
  assign wr_en  = cs & write;
  assign reg_wr = wr_en & addr[13];
  assign ram_wr = wr_en & ~addr[13];

  generate
    if (PIX_BITS >= 3) begin : g_pal_full
      assign pal_ok = 1'b1;
    end else begin : g_pal_part
      assign pal_ok = (addr[2:PIX_BITS] == '0);
    end
  endgenerate

  logic [10:0]   x0_stg, y0_stg, x0_act, y0_act;
  logic          bypass_stg, bypass_act, anim_stg, anim_act;
  logic [FW-1:0] frame_stg, frame_act;
  logic [7:0]    period, divider;
  logic [CD-1:0] palette [NPAL];
`ifdef SPRITE_HFLIP_EN
  logic          hflip_stg, hflip_act;
`endif

  logic at_zero, prev_zero, frame_tick;
  assign at_zero    = (x == 11'd0) && (y == 11'd0);
  assign frame_tick = at_zero & ~prev_zero;

  // Tracks the coordinate even in reset so that reset release never fakes a frame start.
  always_ff @(posedge clk) prev_zero <= at_zero;

  always_ff @(posedge clk) begin
    if (!reset) begin
      x0_stg <= '0; y0_stg <= '0; x0_act <= '0; y0_act <= '0;
      bypass_stg <= 1'b0; bypass_act <= 1'b0;
      anim_stg <= 1'b0; anim_act <= 1'b0;
      frame_stg <= '0; frame_act <= '0;
      period <= '0; divider <= '0;
`ifdef SPRITE_HFLIP_EN
      hflip_stg <= 1'b0; hflip_act <= 1'b0;
`endif
      for (int i = 0; i < NPAL; i++) palette[i] <= '0;
    end else begin
      if (frame_tick) begin
        x0_act     <= x0_stg;
        y0_act     <= y0_stg;
        bypass_act <= bypass_stg;
        anim_act   <= anim_stg;
`ifdef SPRITE_HFLIP_EN
        hflip_act  <= hflip_stg;
`endif
        if (!anim_act) begin
          frame_act <= frame_stg;
          divider   <= '0;
        end else if (divider == period) begin
          divider   <= '0;
          frame_act <= frame_act + 1'b1;
        end else begin
          divider   <= divider + 8'd1;
        end
      end
      if (reg_wr) begin
        if (addr[3]) begin
          if (pal_ok) palette[addr[PIX_BITS-1:0]] <= wr_data[CD-1:0];
        end else begin
          case (addr[2:0])
            3'd0: begin
              bypass_stg <= wr_data[0];
              anim_stg   <= wr_data[2];
`ifdef SPRITE_HFLIP_EN
              hflip_stg  <= wr_data[1];
`endif
            end
            3'd1:    x0_stg    <= wr_data[10:0];
            3'd2:    y0_stg    <= wr_data[10:0];
            3'd3:    frame_stg <= wr_data[FW-1:0];
            3'd4:    period    <= wr_data[7:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Left of / above the origin the unsigned differences wrap large and miss.
  logic [10:0]   dx, dy;
  logic          hit0;
  logic [CW-1:0] col0;
  assign dx   = x - x0_act;
  assign dy   = y - y0_act;
  assign hit0 = (dx < W11) && (dy < H11);
`ifdef SPRITE_HFLIP_EN
  assign col0 = hflip_act ? ~dx[CW-1:0] : dx[CW-1:0];
`else
  assign col0 = dx[CW-1:0];
`endif

  logic [RAM_AW-1:0]   ram_addr1;
  logic                hit1, hit2, byp1, byp2;
  logic [CD-1:0]       rgb1, rgb2;
  logic [PIX_BITS-1:0] idx2;
  logic [PIX_BITS-1:0] ram [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_addr1 <= '0; hit1 <= 1'b0; byp1 <= 1'b0; rgb1 <= '0;
      hit2 <= 1'b0; byp2 <= 1'b0; rgb2 <= '0;
    end else begin
      ram_addr1 <= {frame_act, dy[RW-1:0], col0};
      hit1      <= hit0;
      byp1      <= bypass_act;
      rgb1      <= si_rgb;
      hit2      <= hit1;
      byp2      <= byp1;
      rgb2      <= rgb1;
    end
  end

  // Read-before-write on a shared address: the read register sees the old word.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[addr[RAM_AW-1:0]] <= wr_data[PIX_BITS-1:0];
    idx2 <= ram[ram_addr1];
  end

  assign so_rgb = (byp2 || !hit2 || (idx2 == KEY)) ? rgb2 : palette[idx2];

  logic unused_bits;
  assign unused_bits = ^{wr_data, addr};

endmodule

// File: tb/tb_vga_sprite_anim_core.sv
// Directed bench for vga_sprite_anim_core: expected pixels are queued when driven and
// compared two cycles later when they leave the pipeline.
module tb_vga_sprite_anim_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] x = 11'd5, y = 11'd5;
  logic        cs = 1'b0, write = 1'b0;
  logic [13:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [11:0] si_rgb = 12'hABC;
  logic [11:0] so_rgb;

  vga_sprite_anim_core dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [11:0] exp;
    string       tag;
  } sb_t;

  sb_t  sb [$];
  int   checks = 0;
  int   errors = 0;
  logic rst_val = 1'b0;

  localparam logic [11:0] BLUE = 12'h00F;
  localparam logic [13:0] R_CTRL = 14'h2000, R_X0 = 14'h2001, R_Y0 = 14'h2002;
  localparam logic [13:0] R_FRAME = 14'h2003, R_PERIOD = 14'h2004;

  function automatic logic [11:0] pal(input int i);
    case (i)
      0: return 12'h555;
      1: return 12'hF00;
      2: return 12'h0F0;
      3: return 12'hFF0;
      4: return 12'h0FF;
      5: return 12'hF0F;
      default: return 12'h000;
    endcase
  endfunction

  task automatic step(input int px, input int py, input logic [11:0] prgb, input logic pwe,
                      input logic [13:0] pa, input logic [31:0] pd,
                      input logic pchk, input logic [11:0] pexp, input string ptag);
    sb_t ent;
    @(negedge clk);
    if (sb.size() >= 2) begin
      ent = sb.pop_front();
      if (ent.chk) begin
        checks++;
        assert (so_rgb === ent.exp)
        else begin
          errors++;
          $error("FAIL %s: so_rgb=%h expected=%h", ent.tag, so_rgb, ent.exp);
        end
      end
    end
    reset = rst_val;
    // A pixel still in flight when reset is sampled low is flushed to zero.
    if (!rst_val && sb.size() > 0) begin
      ent = sb.pop_front();
      ent.chk = 1'b1;
      ent.exp = '0;
      ent.tag = "reset_flush";
      sb.push_back(ent);
    end
    x = 11'(px); y = 11'(py); si_rgb = prgb;
    cs = pwe; write = pwe; addr = pa; wr_data = pd;
    ent.chk = rst_val ? pchk : 1'b1;
    ent.exp = rst_val ? pexp : 12'h000;
    ent.tag = rst_val ? ptag : "reset_zero";
    sb.push_back(ent);
  endtask

  task automatic px(input int cx, input int cy, input logic [11:0] rgb,
                    input logic [11:0] e, input string t);
    step(cx, cy, rgb, 1'b0, 14'h0, 32'h0, 1'b1, e, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1000, 1000, 12'h000, 1'b0, 14'h0, 32'h0, 1'b0, 12'h0, "");
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    step(1000, 1000, 12'h000, 1'b1, a, d, 1'b0, 12'h0, "");
  endtask

  task automatic frame_start(input int hold);
    step(999, 999, 12'h000, 1'b0, 14'h0, 32'h0, 1'b0, 12'h0, "");
    for (int i = 0; i < hold; i++) step(0, 0, 12'h000, 1'b0, 14'h0, 32'h0, 1'b0, 12'h0, "");
  endtask

  int seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    // reset state
    rst_val = 1'b0;
    for (int i = 0; i < 4; i++) px(5, 5, 12'hABC, 12'h000, "");
    rst_val = 1'b1;
    px(500, 400, 12'h123, 12'h123, "rst_pass");
    idle(2);

    // sprite RAM: frame f filled with index f+1; palette; origin staged at (100,50)
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 64; c++)
          wr(14'(f * 2048 + r * 64 + c), 32'(f + 1));
    for (int i = 0; i < 6; i++) wr(14'h2008 + 14'(i), 32'(pal(i)));
    wr(R_X0, 32'd100);
    wr(R_Y0, 32'd50);
    wr(R_CTRL, 32'd0);
    idle(1);
    px(100, 50, BLUE, BLUE, "staged_not_active");
    idle(2);

    frame_start(1);
    px(100, 50, BLUE, pal(1), "hit_origin");
    px(99, 50, BLUE, BLUE, "miss_left");
    px(164, 50, BLUE, BLUE, "miss_right");
    px(163, 81, BLUE, pal(1), "hit_corner");
    px(163, 82, BLUE, BLUE, "miss_below");
    px(100, 49, BLUE, BLUE, "miss_above");
    idle(2);

    // mid-frame move
    wr(R_X0, 32'd200);
    px(100, 50, BLUE, pal(1), "move_holds");
    idle(2);
    frame_start(1);
    px(100, 50, BLUE, BLUE, "move_old_gone");
    px(200, 50, BLUE, pal(1), "move_new");
    idle(1);

    // write landing on the frame_tick cycle
    step(0, 0, BLUE, 1'b1, R_X0, 32'd300, 1'b0, 12'h0, "");
    px(200, 50, BLUE, pal(1), "coinc_old");
    px(300, 50, BLUE, BLUE, "coinc_not_yet");
    idle(2);
    frame_start(1);
    px(300, 50, BLUE, pal(1), "coinc_new");
    idle(2);

    // animation, period 2; one long (0,0) hold must count as a single tick
    wr(R_PERIOD, 32'd2);
    wr(R_CTRL, 32'd4);
    frame_start(1);
    for (int k = 0; k < 13; k++) begin
      px(300, 50, BLUE, pal(seq[k] + 1), $sformatf("anim_%0d", k));
      idle(2);
      frame_start(k == 4 ? 3 : 1);
    end
    wr(R_CTRL, 32'd0);
    wr(R_FRAME, 32'd2);
    frame_start(1);
    px(300, 50, BLUE, pal(1), "anim_stop_lag");
    idle(2);
    frame_start(1);
    px(300, 50, BLUE, pal(3), "manual_frame");
    idle(2);
    wr(R_FRAME, 32'd0);
    frame_start(1);

    // transparent key at frame 0, row 0, col 5
    wr(14'd5, 32'd0);
    idle(1);
    px(305, 50, 12'h246, 12'h246, "key_transparent");
    px(306, 50, 12'h246, pal(1), "key_neighbour");
    idle(2);

    // mirroring: index 5 at frame 0, row 1, col 0
    wr(14'd64, 32'd5);
    wr(R_CTRL, 32'd2);
    frame_start(1);
`ifdef SPRITE_HFLIP_EN
    px(363, 51, BLUE, pal(5), "hflip_col0_at_dx63");
    px(300, 51, BLUE, pal(1), "hflip_dx0");
`else
    px(300, 51, BLUE, pal(5), "noflip_col0_at_dx0");
    px(363, 51, BLUE, pal(1), "noflip_dx63");
`endif
    idle(2);

    // bypass
    wr(R_CTRL, 32'd1);
    px(306, 50, 12'h321, pal(1), "bypass_staged");
    idle(2);
    frame_start(1);
    px(306, 50, 12'h321, 12'h321, "bypass_on");
    px(320, 60, 12'h654, 12'h654, "bypass_on2");
    idle(2);

    // reset in the middle of a visible frame
    wr(R_CTRL, 32'd0);
    frame_start(1);
    px(310, 50, BLUE, pal(1), "pre_reset_visible");
    idle(2);
    rst_val = 1'b0;
    for (int i = 0; i < 3; i++) px(311, 50, 12'h0AA, 12'h000, "");
    rst_val = 1'b1;
    px(310, 50, 12'h0AB, 12'h0AB, "post_reset_pass");
    px(320, 60, 12'h0AC, 12'h0AC, "post_reset_pass2");
    idle(2);
    frame_start(1);
    px(310, 50, 12'h0AD, 12'h0AD, "post_reset_commit");
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
